// File: rtl/dsp_add_i8_4_sched_if.sv
// Handshake bundle for the two-requester i8x4 adder scheduler.
// slave = scheduler side, master = requesters plus shared adder.
interface dsp_add_i8_4_sched_if;
  logic        r0_valid;
  logic        r0_ready;
  logic [31:0] r0_a;
  logic [31:0] r0_b;
  logic        r0_res_valid;
  logic        r0_res_ready;
  logic [31:0] r0_res_y;
  logic        r1_valid;
  logic        r1_ready;
  logic [31:0] r1_a;
  logic [31:0] r1_b;
  logic        r1_res_valid;
  logic        r1_res_ready;
  logic [31:0] r1_res_y;
  logic [31:0] dsp_a;
  logic [31:0] dsp_b;
  logic [31:0] dsp_y;
  logic        busy;

  modport slave (
    input  r0_valid, r0_a, r0_b, r0_res_ready,
    input  r1_valid, r1_a, r1_b, r1_res_ready,
    input  dsp_y,
    output r0_ready, r0_res_valid, r0_res_y,
    output r1_ready, r1_res_valid, r1_res_y,
    output dsp_a, dsp_b, busy
  );

  modport master (
    output r0_valid, r0_a, r0_b, r0_res_ready,
    output r1_valid, r1_a, r1_b, r1_res_ready,
    output dsp_y,
    input  r0_ready, r0_res_valid, r0_res_y,
    input  r1_ready, r1_res_valid, r1_res_y,
    input  dsp_a, dsp_b, busy
  );
endinterface

// File: rtl/dsp_add_i8_4_sched.sv
// Round-robin, credit-based sharing of one pipelined i8x4 adder
// between two requesters, with per-requester in-order result FIFOs.
module dsp_add_i8_4_sched #(
  parameter int LAT   = 2,
  parameter int DEPTH = 2
) (
  input logic                 clock,
  input logic                 reset,
  dsp_add_i8_4_sched_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DEPTHC = 4'(DEPTH);

  logic [1:0]       vld;
  logic [1:0]       hasc;
  logic [1:0]       elig;
  logic [1:0]       rdy;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       rvld;
  logic [1:0]       rrdy;
  logic [1:0][31:0] ra;
  logic [1:0][31:0] rb;
  logic [1:0][31:0] ry;
  logic [LAT-1:0]   tv;
  logic [LAT-1:0]   tid;
  logic             ptr;
  logic             g0;
  logic             g1;

  assign vld  = {bus.r1_valid, bus.r0_valid};
  assign rrdy = {bus.r1_res_ready, bus.r0_res_ready};
  assign ra   = {bus.r1_a, bus.r0_a};
  assign rb   = {bus.r1_b, bus.r0_b};

  // reset gating keeps ready/operands low while reset is held
  always_comb begin
    elig = vld & hasc;
    g0 = reset && elig[0] && (!elig[1] || !ptr);
    g1 = reset && elig[1] && (!elig[0] || ptr);
  end

  assign rdy = {g1, g0};
  assign bus.r0_ready = g0;
  assign bus.r1_ready = g1;

  assign bus.dsp_a = g0 ? ra[0] : (g1 ? ra[1] : '0);
  assign bus.dsp_b = g0 ? rb[0] : (g1 ? rb[1] : '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tv  <= '0;
      tid <= '0;
      ptr <= 1'b0;
    end else begin
      tv[0]  <= g0 | g1;
      tid[0] <= g1;
      for (int k = 1; k < LAT; k++) begin
        tv[k]  <= tv[k-1];
        tid[k] <= tid[k-1];
      end
      if (g0 | g1) ptr <= g0;
    end
  end

  assign push[0] = tv[LAT-1] & ~tid[LAT-1];
  assign push[1] = tv[LAT-1] & tid[LAT-1];
  assign pop     = rvld & rrdy;

  for (genvar r = 0; r < 2; r++) begin : g_buf
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [3:0]    cnt;
    logic [3:0]    cred;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        wp   <= '0;
        rp   <= '0;
        cnt  <= '0;
        cred <= DEPTHC;
      end else begin
        if (push[r]) wp <= (wp == LAST) ? '0 : wp + 1'b1;
        if (pop[r])  rp <= (rp == LAST) ? '0 : rp + 1'b1;
        cnt  <= cnt + {3'b0, push[r]}
                    - {3'b0, pop[r]};
        cred <= cred - {3'b0, rdy[r]}
                     + {3'b0, pop[r]};
      end
    end

    always_ff @(posedge clock) begin
      if (push[r]) mem[wp] <= bus.dsp_y;
    end

    assign hasc[r] = (cred != '0);
    assign rvld[r] = (cnt != '0);
    assign ry[r]   = rvld[r] ? mem[rp] : '0;
  end

  assign bus.r0_res_valid = rvld[0];
  assign bus.r1_res_valid = rvld[1];
  assign bus.r0_res_y     = ry[0];
  assign bus.r1_res_y     = ry[1];

  assign bus.busy = (|tv) | (|rvld);
endmodule

// File: tb/tb_dsp_add_i8_4_sched.sv
// Directed bench for dsp_add_i8_4_sched at LAT=2, DEPTH=2.
// The shared adder is modelled as a 2-stage lane-wise i8 adder.
module tb_dsp_add_i8_4_sched;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   errs   = 0;
  int   checks = 0;

  dsp_add_i8_4_sched_if bus();

  dsp_add_i8_4_sched #(
    .LAT   (2),
    .DEPTH (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] lsum(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = a[8*i +: 8] + b[8*i +: 8];
    return r;
  endfunction

  logic [31:0] sa0 = '0;
  logic [31:0] sa1 = '0;
  always @(posedge clock) begin
    sa1 <= sa0;
    sa0 <= lsum(bus.dsp_a, bus.dsp_b);
  end
  assign bus.dsp_y = sa1;

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic idle;
    bus.r0_valid = 0; bus.r0_a = '0; bus.r0_b = '0;
    bus.r1_valid = 0; bus.r1_a = '0; bus.r1_b = '0;
    bus.r0_res_ready = 0;
    bus.r1_res_ready = 0;
  endtask

  task automatic test_reset;
    reset = 0;
    idle();
    bus.r0_valid = 1; bus.r0_a = 32'h01020304;
    bus.r1_valid = 1; bus.r1_b = 32'h05060708;
    step(); step(); #1;
    checks++; if (bus.r0_ready !== 1'b0) begin errs++; $display("FAIL rst_r0_ready: got %b want 0", bus.r0_ready); end
    checks++; if (bus.r1_ready !== 1'b0) begin errs++; $display("FAIL rst_r1_ready: got %b want 0", bus.r1_ready); end
    checks++; if (bus.dsp_a !== 32'h0) begin errs++; $display("FAIL rst_dsp_a: got %h want 0", bus.dsp_a); end
    checks++; if (bus.dsp_b !== 32'h0) begin errs++; $display("FAIL rst_dsp_b: got %h want 0", bus.dsp_b); end
    checks++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    checks++; if (bus.r0_res_valid !== 1'b0) begin errs++; $display("FAIL rst_r0_rv: got %b want 0", bus.r0_res_valid); end
    checks++; if (bus.r1_res_valid !== 1'b0) begin errs++; $display("FAIL rst_r1_rv: got %b want 0", bus.r1_res_valid); end
    checks++; if (bus.r0_res_y !== 32'h0) begin errs++; $display("FAIL rst_r0_y: got %h want 0", bus.r0_res_y); end
    checks++; if (bus.r1_res_y !== 32'h0) begin errs++; $display("FAIL rst_r1_y: got %h want 0", bus.r1_res_y); end
    idle();
    reset = 1;
  endtask

  task automatic test_single;
    step();
    bus.r0_valid = 1;
    bus.r0_a = 32'h04030201;
    bus.r0_b = 32'h10101010;
    #1;
    checks++; if (bus.r0_ready !== 1'b1) begin errs++; $display("FAIL single_ready: got %b want 1", bus.r0_ready); end
    checks++; if (bus.r1_ready !== 1'b0) begin errs++; $display("FAIL single_r1_ready: got %b want 0", bus.r1_ready); end
    checks++; if (bus.dsp_a !== 32'h04030201) begin errs++; $display("FAIL single_dsp_a: got %h want 04030201", bus.dsp_a); end
    checks++; if (bus.dsp_b !== 32'h10101010) begin errs++; $display("FAIL single_dsp_b: got %h want 10101010", bus.dsp_b); end
    step();
    bus.r0_valid = 0;
    #1;
    checks++; if (bus.dsp_a !== 32'h0) begin errs++; $display("FAIL single_dsp_idle: got %h want 0", bus.dsp_a); end
    checks++; if (bus.busy !== 1'b1) begin errs++; $display("FAIL single_busy: got %b want 1", bus.busy); end
    step(); #1;
    checks++; if (bus.r0_res_valid !== 1'b0) begin errs++; $display("FAIL single_early: got %b want 0", bus.r0_res_valid); end
    step(); #1;
    checks++; if (bus.r0_res_valid !== 1'b1) begin errs++; $display("FAIL single_rv_c3: got %b want 1", bus.r0_res_valid); end
    checks++; if (bus.r0_res_y !== 32'h14131211) begin errs++; $display("FAIL single_y: got %h want 14131211", bus.r0_res_y); end
    checks++; if (bus.r1_res_valid !== 1'b0) begin errs++; $display("FAIL single_r1_rv: got %b want 0", bus.r1_res_valid); end
    bus.r0_res_ready = 1;
    step();
    bus.r0_res_ready = 0;
    #1;
    checks++; if (bus.r0_res_valid !== 1'b0) begin errs++; $display("FAIL single_popped: got %b want 0", bus.r0_res_valid); end
    checks++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL single_idle_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_wrap;
    step();
    bus.r1_valid = 1;
    bus.r1_a = 32'hFF807F01;
    bus.r1_b = 32'h01800101;
    #1;
    checks++; if (bus.r1_ready !== 1'b1) begin errs++; $display("FAIL wrap_ready: got %b want 1", bus.r1_ready); end
    step();
    bus.r1_valid = 0;
    step(); step(); #1;
    checks++; if (bus.r1_res_valid !== 1'b1) begin errs++; $display("FAIL wrap_rv: got %b want 1", bus.r1_res_valid); end
    checks++; if (bus.r1_res_y !== 32'h00008002) begin errs++; $display("FAIL wrap_y: got %h want 00008002", bus.r1_res_y); end
    bus.r1_res_ready = 1;
    step();
    bus.r1_res_ready = 0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL wrap_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_back_to_back;
    int k0 = 0, k1 = 0, n0 = 0, n1 = 0;
    step();
    bus.r0_b = 32'h01010101;
    bus.r1_b = 32'h02020202;
    bus.r0_res_ready = 1;
    bus.r1_res_ready = 1;
    for (int c = 0; c < 16; c++) begin
      bus.r0_valid = (c < 8);
      bus.r1_valid = (c < 8);
      bus.r0_a = 32'h10203040 + k0;
      bus.r1_a = 32'hA0B0C0D0 + k1;
      #1;
      if (c < 8) begin
        checks++; if (bus.r0_ready !== (c % 2 == 0)) begin errs++; $display("FAIL b2b_r0_ready c%0d: got %b want %b", c, bus.r0_ready, (c % 2 == 0)); end
        checks++; if (bus.r1_ready !== (c % 2 == 1)) begin errs++; $display("FAIL b2b_r1_ready c%0d: got %b want %b", c, bus.r1_ready, (c % 2 == 1)); end
      end
      if (bus.r0_ready) k0++;
      if (bus.r1_ready) k1++;
      if (bus.r0_res_valid) begin
        checks++; if (bus.r0_res_y !== 32'h11213141 + n0) begin errs++; $display("FAIL b2b_r0_y #%0d: got %h want %h", n0, bus.r0_res_y, 32'h11213141 + n0); end
        n0++;
      end
      if (bus.r1_res_valid) begin
        checks++; if (bus.r1_res_y !== 32'hA2B2C2D2 + n1) begin errs++; $display("FAIL b2b_r1_y #%0d: got %h want %h", n1, bus.r1_res_y, 32'hA2B2C2D2 + n1); end
        n1++;
      end
      step();
    end
    checks++; if (n0 != 4) begin errs++; $display("FAIL b2b_r0_count: got %0d want 4", n0); end
    checks++; if (n1 != 4) begin errs++; $display("FAIL b2b_r1_count: got %0d want 4", n1); end
    checks++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL b2b_busy: got %b want 0", bus.busy); end
    idle();
  endtask

  task automatic test_backpressure;
    int g = 0, i0 = 0, i1 = 0;
    step();
    bus.r0_b = 32'h00000003;
    for (int c = 0; c < 6; c++) begin
      bus.r0_valid = 1;
      bus.r0_a = 32'h5 + g;
      #1;
      checks++; if (bus.r0_ready !== (c < 2)) begin errs++; $display("FAIL bp_ready c%0d: got %b want %b", c, bus.r0_ready, (c < 2)); end
      if (bus.r0_ready) g++;
      step();
    end
    checks++; if (bus.r0_res_valid !== 1'b1) begin errs++; $display("FAIL bp_rv: got %b want 1", bus.r0_res_valid); end
    checks++; if (bus.r0_res_y !== 32'h8) begin errs++; $display("FAIL bp_head: got %h want 00000008", bus.r0_res_y); end
    bus.r1_valid = 1;
    bus.r1_a = 32'h11111111;
    bus.r1_b = 32'h22222222;
    #1;
    checks++; if (bus.r1_ready !== 1'b1) begin errs++; $display("FAIL bp_r1_ready: got %b want 1", bus.r1_ready); end
    checks++; if (bus.r0_ready !== 1'b0) begin errs++; $display("FAIL bp_r0_blocked: got %b want 0", bus.r0_ready); end
    step();
    bus.r1_valid = 0;
    bus.r0_res_ready = 1;
    #1;
    checks++; if (bus.r0_ready !== 1'b0) begin errs++; $display("FAIL bp_pop_cycle: got %b want 0", bus.r0_ready); end
    step();
    bus.r0_res_ready = 0;
    bus.r0_a = 32'h7;
    #1;
    checks++; if (bus.r0_ready !== 1'b1) begin errs++; $display("FAIL bp_regrant: got %b want 1", bus.r0_ready); end
    checks++; if (bus.r0_res_y !== 32'h9) begin errs++; $display("FAIL bp_head2: got %h want 00000009", bus.r0_res_y); end
    step();
    bus.r0_valid = 0;
    bus.r0_res_ready = 1;
    bus.r1_res_ready = 1;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (bus.r0_res_valid) begin
        checks++; if (bus.r0_res_y !== ((i0 == 0) ? 32'h9 : 32'hA)) begin errs++; $display("FAIL bp_drain_r0 #%0d: got %h want %h", i0, bus.r0_res_y, ((i0 == 0) ? 32'h9 : 32'hA)); end
        i0++;
      end
      if (bus.r1_res_valid) begin
        checks++; if (bus.r1_res_y !== 32'h33333333) begin errs++; $display("FAIL bp_drain_r1: got %h want 33333333", bus.r1_res_y); end
        i1++;
      end
      if (!bus.busy) break;
      step();
    end
    checks++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL bp_drain_timeout: busy=%b want 0", bus.busy); end
    checks++; if (i0 != 2) begin errs++; $display("FAIL bp_r0_count: got %0d want 2", i0); end
    checks++; if (i1 != 1) begin errs++; $display("FAIL bp_r1_count: got %0d want 1", i1); end
    idle();
  endtask

  task automatic test_reset_inflight;
    int n = 0;
    step();
    bus.r0_valid = 1;
    bus.r0_a = 32'h20;
    bus.r0_b = 32'h01;
    #1;
    checks++; if (bus.r0_ready !== 1'b1) begin errs++; $display("FAIL ri_g0: got %b want 1", bus.r0_ready); end
    step();
    bus.r0_a = 32'h21;
    #1;
    checks++; if (bus.r0_ready !== 1'b1) begin errs++; $display("FAIL ri_g1: got %b want 1", bus.r0_ready); end
    step();
    bus.r0_valid = 0;
    step(); #1;
    checks++; if (bus.r0_res_valid !== 1'b1) begin errs++; $display("FAIL ri_buffered: got %b want 1", bus.r0_res_valid); end
    #1;
    reset = 0;
    #1;
    checks++; if (bus.r0_res_valid !== 1'b0) begin errs++; $display("FAIL ri_rv_drop: got %b want 0", bus.r0_res_valid); end
    checks++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL ri_busy_drop: got %b want 0", bus.busy); end
    checks++; if (bus.r0_res_y !== 32'h0) begin errs++; $display("FAIL ri_y_zero: got %h want 0", bus.r0_res_y); end
    step(); step();
    reset = 1;
    bus.r0_valid = 1;
    bus.r0_a = 32'h40;
    #1;
    checks++; if (bus.r0_ready !== 1'b1) begin errs++; $display("FAIL ri_new_g0: got %b want 1", bus.r0_ready); end
    step();
    bus.r0_a = 32'h41;
    #1;
    checks++; if (bus.r0_ready !== 1'b1) begin errs++; $display("FAIL ri_new_g1: got %b want 1", bus.r0_ready); end
    step();
    bus.r0_valid = 0;
    bus.r0_res_ready = 1;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (bus.r0_res_valid) begin
        checks++; if (bus.r0_res_y !== ((n == 0) ? 32'h41 : 32'h42)) begin errs++; $display("FAIL ri_res #%0d: got %h want %h", n, bus.r0_res_y, ((n == 0) ? 32'h41 : 32'h42)); end
        n++;
      end
      if (!bus.busy) break;
      step();
    end
    checks++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL ri_drain_timeout: busy=%b want 0", bus.busy); end
    checks++; if (n != 2) begin errs++; $display("FAIL ri_count: got %0d want 2", n); end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_single();
    test_wrap();
    test_back_to_back();
    test_backpressure();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end
endmodule

// File: doc/dsp_add_i8_4_sched.md
DSP_ADD_I8_4_SCHED -- requirements
Module: dsp_add_i8_4_sched

Interface
REQ-001 SHALL have parameter LAT, default 2: cycles from operands presented on dsp_a/dsp_b to matching sum on dsp_y; legal 1..4.
REQ-002 SHALL have parameter DEPTH, default 2: result-buffer entries per requester; power of two, 1..8.
REQ-003 SHALL have port clock  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports r0_valid / r1_valid  in  1  request valid.
REQ-006 SHALL have ports r0_ready / r1_ready  out  1  request accepted this cycle.
REQ-007 SHALL have ports r0_a, r0_b, r1_a, r1_b  in  32  four i8 lanes, lane i = bits [8i+7:8i].
REQ-008 SHALL have ports r0_res_valid / r1_res_valid  out  1  result available.
REQ-009 SHALL have ports r0_res_ready / r1_res_ready  in  1  result consumed.
REQ-010 SHALL have ports r0_res_y / r1_res_y  out  32  lane-wise sums, same packing.
REQ-011 SHALL have ports dsp_a, dsp_b  out  32  operands to the shared SIMD (FOUR12) adder.
REQ-012 SHALL have port dsp_y  in  32  adder result, lanes repacked to 8-bit stride.
REQ-013 SHALL have port busy  out  1  any request in flight or buffered.

Function
REQ-014 Request handshake SHALL complete when rX_valid && rX_ready; at most one grant per cycle.
REQ-015 Requester X SHALL be eligible only if rX_valid=1 and credit_X>0.
REQ-016 credit_X SHALL equal DEPTH minus (in-flight + buffered results for X): -1 on grant, +1 on result pop, unchanged when both occur in the same cycle.
REQ-017 Arbitration SHALL be round-robin: pointer names the preferred requester; if only one is eligible it wins; after a grant the pointer moves to the other requester; pointer unchanged with no grant.
REQ-018 rX_ready SHALL be combinational from the grant decision (may depend on rX_valid).
REQ-019 In grant cycle t, dsp_a/dsp_b SHALL carry the winner's a/b; with no grant they SHALL be 0.
REQ-020 A LAT-stage tag pipeline (valid + requester id) SHALL track each grant; dsp_y in cycle t+LAT SHALL be written into the owner's result buffer at the end of that cycle.
REQ-021 Lane arithmetic is performed by the adder, modulo 256 per lane, no inter-lane carry; the block SHALL pass dsp_y unmodified.
REQ-022 Each result buffer SHALL be FIFO, in issue order; rX_res_valid=1 while non-empty; rX_res_y shows head entry; pop on rX_res_valid && rX_res_ready.
REQ-023 Issue-to-rX_res_valid latency SHALL be LAT+1 cycles (3 at default) when the buffer is empty.
REQ-024 Buffer push and pop in the same cycle SHALL both take effect; the credit rule guarantees no overflow, and writes to a full buffer never occur.
REQ-025 One requester's backpressure SHALL NOT block the other requester.
REQ-026 Back-to-back grants SHALL be allowed every cycle (full adder throughput).
REQ-027 busy SHALL be 1 iff any tag stage is valid or any buffer is non-empty.

Reset
REQ-028 reset=0 SHALL immediately (asynchronously) clear tag pipeline, empty both buffers, set credits to DEPTH, and set pointer to r0.
REQ-029 During reset: r0_ready, r1_ready, res_valid, busy, dsp_a, dsp_b SHALL be 0; res_y SHALL be 0.
REQ-030 Results in flight at reset assertion SHALL be discarded; first grant is possible in the first clock edge after reset=1.

Verification (LAT=2, DEPTH=2)
REQ-031 r0 only, cycle 0: r0_a=0x04030201, r0_b=0x10101010 -> r0_ready=1 in cycle 0; dsp_y model; r0_res_valid=1 in cycle 3, r0_res_y=0x14131211.
REQ-032 Lane wrap: r1_a=0xFF807F01, r1_b=0x01800101 -> r1_res_y=0x00008002; no carry into neighbouring lanes.
REQ-033 Both valid every cycle, res_ready=1 -> grants r0,r1,r0,r1...; each requester's results returned in order, one per two cycles.
REQ-034 r0 valid continuously, r0_res_ready=0, r1 idle -> exactly 2 r0 grants, then r0_ready=0; raise r0_res_ready one cycle -> one pop and one new grant in the next cycle; r1 requests meanwhile still granted.
REQ-035 reset=0 with one result in flight and one buffered -> res_valid and busy drop to 0 immediately; after release, two new r0 grants accepted with no stale results returned.
